pca_reg_arbiter: RTL and testbench
==================================

PCA_REG_ARBITER -- requirements
Module: pca_reg_arbiter

Interface
REQ-001 SHALL have port: clk_i  in  1  sole clock; every flop is rising-edge.
REQ-002 SHALL have port: rst_i  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port: i2c_wr_en_i  in  1  one-cycle write strobe from the I2C target; no backpressure.
REQ-004 SHALL have ports: i2c_wr_id_i  in  8, i2c_wr_val_i  in  8  compact register index and data, valid with the strobe.
REQ-005 SHALL have port: int_req_i  in  1  internal write request (e.g. MODE1 RESTART auto-update), held until granted.
REQ-006 SHALL have ports: int_wr_id_i  in  8, int_wr_val_i  in  8  internal index and data, stable while int_req_i is high.
REQ-007 SHALL have port: int_gnt_o  out  1  one-cycle grant, coincident with the issued write.
REQ-008 SHALL have port: soft_rst_ni  in  1  active-low soft-reset pulse from the I2C target.
REQ-009 SHALL have ports: reg_wr_en_o  out  1, reg_wr_id_o  out  8, reg_wr_val_o  out  8  single register-storage write port.
REQ-010 SHALL have port: busy_o  out  1  high while in SWEEP or DRAIN.
REQ-011 SHALL have port: sweep_done_o  out  1  one-cycle pulse on the last default write.
REQ-012 SHALL have port: drop_o  out  1  one-cycle pulse when an I2C write is discarded.

Function
REQ-013 SHALL implement FSM states IDLE, SWEEP, DRAIN; DRAIN exists only with PCA_ARB_FIFO_EN.
REQ-014 SHALL register all outputs; a write is issued 1 cycle after its request or strobe is sampled.
REQ-015 IDLE: SHALL issue an I2C strobe with priority over internal; a concurrent int_req_i waits without a grant.
REQ-016 IDLE: SHALL grant an internal request when no I2C strobe is present; at most one write per cycle.
REQ-017 A sampled soft_rst_ni=0 SHALL move to SWEEP with index 0 from any state, including mid-SWEEP (restart at 0).
REQ-018 SWEEP: SHALL write index k with pca_default(k) in consecutive cycles, k = 0..PCA_TOTAL_REGISTERS-1, with no gaps.
REQ-019 SWEEP: SHALL assert sweep_done_o with the write of index PCA_TOTAL_REGISTERS-1, then go to IDLE (or DRAIN when the FIFO is non-empty).
REQ-020 SWEEP: SHALL hold internal requests ungranted and SHALL handle I2C strobes per REQ-025/026.
REQ-021 The index counter SHALL be wide enough for PCA_TOTAL_REGISTERS without wrap.
REQ-022 Outside issued writes, reg_wr_en_o SHALL be 0, and id/val SHALL hold their last values.

Reset
REQ-023 rst_i SHALL asynchronously force IDLE, index 0, FIFO empty, and all outputs 0.
REQ-024 rst_i SHALL NOT trigger a sweep; storage initialises itself, and only soft_rst_ni sweeps.

Configuration
REQ-025 With PCA_ARB_FIFO_EN defined: I2C strobes during SWEEP SHALL enter a 2-entry FIFO.
REQ-025a DRAIN SHALL replay the FIFO one write per cycle, in order, then go to IDLE.
REQ-025b A strobe arriving while the FIFO is full SHALL be discarded and SHALL pulse drop_o.
REQ-025c A strobe arriving during DRAIN SHALL be appended to the FIFO tail.
REQ-026 Without PCA_ARB_FIFO_EN: I2C strobes during SWEEP SHALL be discarded and SHALL pulse drop_o; no FIFO flops are generated.

Structure
REQ-027 The shared package pca_registers.vh SHALL hold PCA_TOTAL_REGISTERS, the register indices, and the pca_default() table.
REQ-027a pca_default() SHALL give MODE1=0x11, MODE2=0x04, SUBADR1..3=0xE2/0xE4/0xE8, ALLCALLADR=0xE0, LEDn_OFF_H=0x10, PRE_SCALE=0x1E, and all others 0x00.
REQ-028 SHALL define state encodings as localparams in this module.
REQ-029 The FIFO SHALL be a sub-module pca_wr_fifo (depth 2, 16-bit entries), instantiated only under PCA_ARB_FIFO_EN.

Verification
REQ-030 I2C strobe id=0x06 val=0xAB in IDLE -> next cycle reg_wr_en_o=1, id=0x06, val=0xAB; int_gnt_o=0.
REQ-031 I2C strobe and int_req (id=0x01, val=0x04) in the same cycle -> I2C write first; internal write and int_gnt_o one cycle later.
REQ-032 soft_rst_ni low 1 cycle -> PCA_TOTAL_REGISTERS back-to-back writes; index 0 = 0x11, index 1 = 0x04; sweep_done_o on the last; busy_o high throughout.
REQ-033 Second soft_rst_ni pulse at sweep index 10 -> the next write is index 0, and a full sweep completes.
REQ-034 FIFO_EN: 3 I2C strobes during SWEEP -> first 2 replayed in order after sweep_done_o; third pulses drop_o. Without FIFO_EN: all 3 pulse drop_o, no replay.
REQ-035 rst_i asserted mid-SWEEP -> outputs 0 immediately; after release, IDLE with no further sweep writes.

Source files
------------

// File: rtl/pca_reg_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : pca_reg_arbiter_pkg                                           |
// | Brief  : Compact PCA9685 register map, register count and power-on     |
// |          default table shared by the register-write arbiter.           |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
package pca_reg_arbiter_pkg;

    // Compact index space: 0..5 control, 6..69 LED0..LED15 (ON_L, ON_H,
    // OFF_L, OFF_H), 70..73 ALL_LED, 74 PRE_SCALE, 75 TESTMODE.
    localparam int PCA_TOTAL_REGISTERS = 76;
    localparam int PCA_IDX_W           = $clog2(PCA_TOTAL_REGISTERS);

    localparam logic [PCA_IDX_W-1:0] PCA_LAST_IDX = PCA_IDX_W'(PCA_TOTAL_REGISTERS - 1);

    localparam logic [7:0] PCA_MODE1         = 8'd0;
    localparam logic [7:0] PCA_MODE2         = 8'd1;
    localparam logic [7:0] PCA_SUBADR1       = 8'd2;
    localparam logic [7:0] PCA_SUBADR2       = 8'd3;
    localparam logic [7:0] PCA_SUBADR3       = 8'd4;
    localparam logic [7:0] PCA_ALLCALLADR    = 8'd5;
    localparam logic [7:0] PCA_LED0_ON_L     = 8'd6;
    localparam logic [7:0] PCA_LED15_OFF_H   = 8'd69;
    localparam logic [7:0] PCA_ALL_LED_ON_L  = 8'd70;
    localparam logic [7:0] PCA_ALL_LED_OFF_H = 8'd73;
    localparam logic [7:0] PCA_PRE_SCALE     = 8'd74;
    localparam logic [7:0] PCA_TESTMODE      = 8'd75;

    // Power-on value of a compact register index.
    function automatic logic [7:0] pca_default(input logic [7:0] idx);
        logic [7:0] v;
        v = 8'h00;
        if      (idx == PCA_MODE1)      v = 8'h11;
        else if (idx == PCA_MODE2)      v = 8'h04;
        else if (idx == PCA_SUBADR1)    v = 8'hE2;
        else if (idx == PCA_SUBADR2)    v = 8'hE4;
        else if (idx == PCA_SUBADR3)    v = 8'hE8;
        else if (idx == PCA_ALLCALLADR) v = 8'hE0;
        else if (idx == PCA_PRE_SCALE)  v = 8'h1E;
        // LEDn_OFF_H sits at 6 + 4n + 3, i.e. index mod 4 == 1 inside the LED block.
        else if ((idx >= PCA_LED0_ON_L) && (idx <= PCA_LED15_OFF_H) && (idx[1:0] == 2'b01))
            v = 8'h10;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pca_reg_arbiter_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : pca_wr_fifo                                                   |
// | Brief  : Two-entry, 16-bit write FIFO ({id, val}) that parks I2C        |
// |          writes arriving during a default sweep. Push and pop may       |
// |          occur in the same cycle; the parent never pushes when full     |
// |          nor pops when empty.                                          |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module pca_wr_fifo (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic [15:0] i_data,
    output logic [15:0] o_head,
    output logic        o_full,
    output logic        o_empty,
    output logic [1:0]  o_count
);

    logic [15:0] r_mem0;
    logic [15:0] r_mem1;
    logic [1:0]  r_count;

    // Shift-register storage: entry 0 is always the head.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mem0  <= '0;
            r_mem1  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_mem0 <= i_data;
                    else                 r_mem1 <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_mem0  <= r_mem1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_mem0 <= i_data;
                    end else begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head  = r_mem0;
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pca_reg_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : pca_reg_arbiter                                               |
// | Brief  : Single write port arbiter for PCA register storage. Merges    |
// |          I2C strobes (priority) and held internal requests, and runs a  |
// |          default-value sweep on soft reset. Optional macro              |
// |          PCA_ARB_FIFO_EN parks I2C writes seen during a sweep in a      |
// |          2-entry FIFO and replays them afterwards (DRAIN state).        |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module pca_reg_arbiter
    import pca_reg_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       i2c_wr_en_i,
    input  logic [7:0] i2c_wr_id_i,
    input  logic [7:0] i2c_wr_val_i,
    input  logic       int_req_i,
    input  logic [7:0] int_wr_id_i,
    input  logic [7:0] int_wr_val_i,
    output logic       int_gnt_o,
    input  logic       soft_rst_ni,
    output logic       reg_wr_en_o,
    output logic [7:0] reg_wr_id_o,
    output logic [7:0] reg_wr_val_o,
    output logic       busy_o,
    output logic       sweep_done_o,
    output logic       drop_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
`ifdef PCA_ARB_FIFO_EN
    localparam logic [1:0] S_DRAIN = 2'd2;
`endif

    logic [1:0]           r_state;
    logic [PCA_IDX_W-1:0] r_idx;
    logic                 r_wr_en;
    logic [7:0]           r_wr_id;
    logic [7:0]           r_wr_val;
    logic                 r_gnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_drop;

    // A sampled soft reset issues the index-0 write on the same edge, so the
    // sweep has no dead cycle and a mid-sweep restart goes straight to 0.
    logic                 w_sweep_act;
    logic [PCA_IDX_W-1:0] w_sweep_idx;
    logic                 w_sweep_last;

    assign w_sweep_act  = !soft_rst_ni || (r_state == S_SWEEP);
    assign w_sweep_idx  = soft_rst_ni ? r_idx : '0;
    assign w_sweep_last = (w_sweep_idx == PCA_LAST_IDX);

`ifdef PCA_ARB_FIFO_EN
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [15:0] w_head;
    logic [1:0]  w_count;

    // Park strobes during SWEEP/DRAIN; pop one entry per DRAIN cycle unless a
    // soft reset pre-empts the replay.
    always_comb begin
        w_push = i2c_wr_en_i && !w_full && (w_sweep_act || (r_state == S_DRAIN));
        w_pop  = soft_rst_ni && (r_state == S_DRAIN);
    end

    pca_wr_fifo u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({i2c_wr_id_i, i2c_wr_val_i}),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );
`endif

    // Arbitration FSM with registered write port and status pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_wr_en  <= 1'b0;
            r_wr_id  <= 8'h00;
            r_wr_val <= 8'h00;
            r_gnt    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_gnt   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_drop  <= 1'b0;
            if (w_sweep_act) begin
                r_wr_en  <= 1'b1;
                r_wr_id  <= 8'(w_sweep_idx);
                r_wr_val <= pca_default(8'(w_sweep_idx));
                r_busy   <= 1'b1;
                if (w_sweep_last) begin
                    r_done <= 1'b1;
                    r_idx  <= '0;
`ifdef PCA_ARB_FIFO_EN
                    r_state <= (!w_empty || w_push) ? S_DRAIN : S_IDLE;
`else
                    r_state <= S_IDLE;
`endif
                end else begin
                    r_idx   <= w_sweep_idx + PCA_IDX_W'(1);
                    r_state <= S_SWEEP;
                end
`ifdef PCA_ARB_FIFO_EN
                if (i2c_wr_en_i && w_full) r_drop <= 1'b1;
`else
                if (i2c_wr_en_i) r_drop <= 1'b1;
`endif
            end
`ifdef PCA_ARB_FIFO_EN
            else if (r_state == S_DRAIN) begin
                r_wr_en  <= 1'b1;
                r_wr_id  <= w_head[15:8];
                r_wr_val <= w_head[7:0];
                r_busy   <= 1'b1;
                if (i2c_wr_en_i && w_full) r_drop <= 1'b1;
                if ((w_count == 2'd1) && !w_push) r_state <= S_IDLE;
            end
`endif
            else if (i2c_wr_en_i) begin
                r_wr_en  <= 1'b1;
                r_wr_id  <= i2c_wr_id_i;
                r_wr_val <= i2c_wr_val_i;
            end else if (int_req_i) begin
                r_wr_en  <= 1'b1;
                r_wr_id  <= int_wr_id_i;
                r_wr_val <= int_wr_val_i;
                r_gnt    <= 1'b1;
            end
        end
    end

    assign reg_wr_en_o  = r_wr_en;
    assign reg_wr_id_o  = r_wr_id;
    assign reg_wr_val_o = r_wr_val;
    assign int_gnt_o    = r_gnt;
    assign busy_o       = r_busy;
    assign sweep_done_o = r_done;
    assign drop_o       = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_pca_reg_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : tb_pca_reg_arbiter                                            |
// | Brief  : Self-checking bench for pca_reg_arbiter: a queue-based model  |
// |          compared every cycle plus directed literal checks.            |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module tb_pca_reg_arbiter;

    localparam int NREG = 76;
`ifdef PCA_ARB_FIFO_EN
    localparam bit FIFO = 1'b1;
`else
    localparam bit FIFO = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       i2c_wr_en_i = 1'b0;
    logic [7:0] i2c_wr_id_i = 8'h00;
    logic [7:0] i2c_wr_val_i = 8'h00;
    logic       int_req_i = 1'b0;
    logic [7:0] int_wr_id_i = 8'h00;
    logic [7:0] int_wr_val_i = 8'h00;
    logic       soft_rst_ni = 1'b1;
    logic       int_gnt_o;
    logic       reg_wr_en_o;
    logic [7:0] reg_wr_id_o;
    logic [7:0] reg_wr_val_o;
    logic       busy_o;
    logic       sweep_done_o;
    logic       drop_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    pca_reg_arbiter dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i2c_wr_en_i  (i2c_wr_en_i),
        .i2c_wr_id_i  (i2c_wr_id_i),
        .i2c_wr_val_i (i2c_wr_val_i),
        .int_req_i    (int_req_i),
        .int_wr_id_i  (int_wr_id_i),
        .int_wr_val_i (int_wr_val_i),
        .int_gnt_o    (int_gnt_o),
        .soft_rst_ni  (soft_rst_ni),
        .reg_wr_en_o  (reg_wr_en_o),
        .reg_wr_id_o  (reg_wr_id_o),
        .reg_wr_val_o (reg_wr_val_o),
        .busy_o       (busy_o),
        .sweep_done_o (sweep_done_o),
        .drop_o       (drop_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_dflt [0:NREG-1];
    int          m_mode = 0;          // 0 idle, 1 sweep, 2 replay
    int          m_k = 0;
    logic [15:0] m_q [$];
    logic        e_en = 0, e_gnt = 0, e_busy = 0, e_done = 0, e_drop = 0;
    logic [7:0]  e_id = 0, e_val = 0;

    // write log {busy, done, id, val} and drop counter seen by the monitor
    logic [17:0] wlog [$];
    int          n_drop = 0;

    initial begin
        for (int i = 0; i < NREG; i++) m_dflt[i] = 8'h00;
        m_dflt[0] = 8'h11; m_dflt[1] = 8'h04; m_dflt[2] = 8'hE2;
        m_dflt[3] = 8'hE4; m_dflt[4] = 8'hE8; m_dflt[5] = 8'hE0;
        m_dflt[74] = 8'h1E;
        for (int n = 0; n < 16; n++) m_dflt[9 + 4 * n] = 8'h10;
    end

    always @(posedge clk_i) begin
        int          sz;
        logic [15:0] hd;
        if (rst_i) begin
            {e_en, e_gnt, e_busy, e_done, e_drop} = '0;
            e_id = 8'h00; e_val = 8'h00;
            m_mode = 0; m_k = 0; m_q.delete();
        end else begin
            {e_en, e_gnt, e_busy, e_done, e_drop} = '0;
            if (!soft_rst_ni) begin m_mode = 1; m_k = 0; end
            sz = m_q.size();
            if (m_mode == 1) begin
                e_en = 1; e_busy = 1; e_id = 8'(m_k); e_val = m_dflt[m_k];
                if (i2c_wr_en_i) begin
                    if (FIFO && sz < 2) m_q.push_back({i2c_wr_id_i, i2c_wr_val_i});
                    else e_drop = 1;
                end
                if (m_k == NREG - 1) begin
                    e_done = 1;
                    m_mode = (m_q.size() > 0) ? 2 : 0;
                end else m_k++;
            end else if (m_mode == 2) begin
                hd = m_q.pop_front();
                e_en = 1; e_busy = 1; e_id = hd[15:8]; e_val = hd[7:0];
                if (i2c_wr_en_i) begin
                    if (sz < 2) m_q.push_back({i2c_wr_id_i, i2c_wr_val_i});
                    else e_drop = 1;
                end
                if (m_q.size() == 0) m_mode = 0;
            end else if (i2c_wr_en_i) begin
                e_en = 1; e_id = i2c_wr_id_i; e_val = i2c_wr_val_i;
            end else if (int_req_i) begin
                e_en = 1; e_gnt = 1; e_id = int_wr_id_i; e_val = int_wr_val_i;
            end
        end
        #1;
        check("wr_en", reg_wr_en_o, e_en);
        check("wr_id", reg_wr_id_o, e_id);
        check("wr_val", reg_wr_val_o, e_val);
        check("int_gnt", int_gnt_o, e_gnt);
        check("busy", busy_o, e_busy);
        check("sweep_done", sweep_done_o, e_done);
        check("drop", drop_o, e_drop);
        if (reg_wr_en_o) wlog.push_back({busy_o, sweep_done_o, reg_wr_id_o, reg_wr_val_o});
        if (drop_o) n_drop++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_soft();
        @(negedge clk_i) soft_rst_ni = 1'b0;
        @(negedge clk_i) soft_rst_ni = 1'b1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (sweep_done_o) return;
        end
        check("sweep_done_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] e;
        int          cnt;
        int          base;
        bit          seen;

        // reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_wr_en", reg_wr_en_o, 0);
        check("rst_id_val", {reg_wr_id_o, reg_wr_val_o}, 16'h0000);
        check("rst_status", {int_gnt_o, busy_o, sweep_done_o, drop_o}, 4'b0000);
        @(negedge clk_i) rst_i = 1'b0;

        // lone I2C strobe in IDLE
        @(negedge clk_i) begin i2c_wr_en_i = 1; i2c_wr_id_i = 8'h06; i2c_wr_val_i = 8'hAB; end
        @(posedge clk_i) #1;
        check("i2c_write", {reg_wr_en_o, reg_wr_id_o, reg_wr_val_o, int_gnt_o}, {1'b1, 8'h06, 8'hAB, 1'b0});
        @(negedge clk_i) i2c_wr_en_i = 0;
        @(posedge clk_i) #1;
        check("idle_hold", {reg_wr_en_o, reg_wr_id_o, reg_wr_val_o}, {1'b0, 8'h06, 8'hAB});

        // simultaneous I2C strobe and internal request
        @(negedge clk_i) begin
            i2c_wr_en_i = 1; i2c_wr_id_i = 8'h33; i2c_wr_val_i = 8'h5A;
            int_req_i = 1; int_wr_id_i = 8'h01; int_wr_val_i = 8'h04;
        end
        @(posedge clk_i) #1;
        check("prio_i2c_first", {reg_wr_en_o, reg_wr_id_o, reg_wr_val_o, int_gnt_o}, {1'b1, 8'h33, 8'h5A, 1'b0});
        @(negedge clk_i) i2c_wr_en_i = 0;
        @(posedge clk_i) #1;
        check("prio_int_next", {reg_wr_en_o, reg_wr_id_o, reg_wr_val_o, int_gnt_o}, {1'b1, 8'h01, 8'h04, 1'b1});
        @(negedge clk_i) int_req_i = 0;

        // full default sweep
        @(negedge clk_i) wlog.delete();
        pulse_soft();
        wait_done();
        @(negedge clk_i);
        check("sweep_len", wlog.size(), NREG);
        cnt = 0;
        for (int i = 0; i < wlog.size(); i++) begin
            e = wlog[i];
            if (e[17] && e[15:8] == 8'(i)) cnt++;
        end
        check("sweep_ordered_busy", cnt, NREG);
        e = wlog[0];  check("sweep_idx0", e[15:0], 16'h0011);
        e = wlog[1];  check("sweep_idx1", e[15:0], 16'h0104);
        e = wlog[5];  check("sweep_allcall", e[15:0], 16'h05E0);
        e = wlog[9];  check("sweep_led0_offh", e[15:0], 16'h0910);
        e = wlog[74]; check("sweep_prescale", e[16:0], {1'b0, 16'h4A1E});
        e = wlog[75]; check("sweep_last_done", e[16:8], {1'b1, 8'h4B});
        check("after_sweep_idle", {reg_wr_en_o, busy_o}, 2'b00);

        // restart mid-sweep at index 10
        wlog.delete();
        pulse_soft();
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_i);
            if (reg_wr_en_o && reg_wr_id_o == 8'd10) seen = 1;
        end
        check("saw_idx10", seen, 1);
        soft_rst_ni = 1'b0;
        @(negedge clk_i) soft_rst_ni = 1'b1;
        wait_done();
        @(negedge clk_i);
        check("restart_len", wlog.size(), 11 + NREG);
        e = wlog[11]; check("restart_idx0", e[15:0], 16'h0011);
        e = wlog[wlog.size() - 1]; check("restart_done", e[16:8], {1'b1, 8'h4B});

        // three strobes during a sweep
        wlog.delete(); n_drop = 0;
        pulse_soft();
        repeat (3) @(negedge clk_i);
        for (int i = 0; i < 3; i++) begin
            i2c_wr_en_i = 1; i2c_wr_id_i = 8'h20 + 8'(i); i2c_wr_val_i = 8'hA0 + 8'(i);
            @(negedge clk_i);
        end
        i2c_wr_en_i = 0;
        wait_done();
        repeat (4) @(negedge clk_i);
        check("sweep_strobe_drops", n_drop, FIFO ? 1 : 3);
        check("sweep_strobe_writes", wlog.size(), FIFO ? NREG + 2 : NREG);
        if (wlog.size() > NREG + 1) begin
            e = wlog[NREG];     check("replay_first", e[17:0], {2'b10, 8'h20, 8'hA0});
            e = wlog[NREG + 1]; check("replay_second", e[17:0], {2'b10, 8'h21, 8'hA1});
        end

        // mixed traffic with occasional soft resets
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_i);
            i2c_wr_en_i  = ($urandom_range(0, 3) == 0);
            i2c_wr_id_i  = 8'($urandom);
            i2c_wr_val_i = 8'($urandom);
            soft_rst_ni  = ($urandom_range(0, 99) != 0);
            if (int_req_i && int_gnt_o) int_req_i = 0;
            else if (!int_req_i && $urandom_range(0, 2) == 0) begin
                int_req_i = 1; int_wr_id_i = 8'($urandom); int_wr_val_i = 8'($urandom);
            end
        end
        @(negedge clk_i) begin i2c_wr_en_i = 0; soft_rst_ni = 1; end
        for (int i = 0; i < 300 && int_req_i; i++) begin
            @(negedge clk_i);
            if (int_gnt_o) int_req_i = 0;
        end
        check("int_req_released", int_req_i, 0);

        // hard reset mid-sweep
        pulse_soft();
        repeat (5) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("async_rst_outputs", {reg_wr_en_o, reg_wr_id_o, reg_wr_val_o, busy_o}, 18'h0);
        @(negedge clk_i) rst_i = 1'b0;
        wlog.delete();
        repeat (100) @(negedge clk_i);
        check("no_sweep_after_rst", wlog.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
